// File: rtl/pcm_to_float.sv
// pcm_to_float: signed 24-bit PCM sample to 24-bit float {sign, exp[6:0], frac[15:0]}.
// Exponent bias 63, hidden leading one, no denormals, zero is the all-zero word.
// Normalisation shifts one bit per cycle by default; defining PCM2F_FAST_NORM_EN
// replaces that with a single-cycle leading-zero count and barrel shift.
module pcm_to_float #(
    parameter int unsigned BIAS = 63,
    parameter int unsigned IN_W = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] pcm_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [23:0]     float_out,
    output logic            inexact,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int unsigned EXP_W   = 7;
    localparam int unsigned FRAC_W  = 16;
    localparam int unsigned KEEP_LO = IN_W - 1 - FRAC_W;  // lsb of kept fraction
    localparam int unsigned GUARD   = KEEP_LO - 1;        // first discarded bit
    localparam int unsigned LZC_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t            state;
    logic              sign;
    logic              zero;
    logic [IN_W-1:0]   mag;
    logic [EXP_W-1:0]  exp;

    logic [IN_W-1:0]   abs_c;
    logic [FRAC_W-1:0] kept_c;
    logic              guard_c;
    logic              sticky_c;
    logic              inc_c;
    logic [FRAC_W:0]   sum_c;
    logic [EXP_W-1:0]  exp_rnd_c;

    // Magnitude of the incoming sample; the most negative code maps to 0x800000.
    always_comb begin
        abs_c = pcm_in;
        if (pcm_in[IN_W-1]) begin
            abs_c = IN_W'(~pcm_in + IN_W'(1));
        end
    end

    // Round-to-nearest-even of the normalised magnitude, with exponent bump on carry-out.
    always_comb begin
        kept_c    = mag[IN_W-2:KEEP_LO];
        guard_c   = mag[GUARD];
        sticky_c  = |mag[GUARD-1:0];
        inc_c     = guard_c & (sticky_c | kept_c[0]);
        sum_c     = {1'b0, kept_c} + (FRAC_W+1)'(inc_c);
        exp_rnd_c = exp + EXP_W'(sum_c[FRAC_W]);
    end

`ifdef PCM2F_FAST_NORM_EN
    logic [LZC_W-1:0] lzc_c;

    // Leading-zero count of mag; the highest set bit wins.
    always_comb begin
        lzc_c = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (mag[i]) begin
                lzc_c = LZC_W'(int'(IN_W) - 1 - i);
            end
        end
    end
`endif

    // Conversion FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            float_out <= '0;
            inexact   <= 1'b0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            mag       <= '0;
            exp       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign     <= pcm_in[IN_W-1];
                        mag      <= abs_c;
                        exp      <= EXP_W'(IN_W - 1 + BIAS);
                        zero     <= (pcm_in == '0);
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
`ifdef PCM2F_FAST_NORM_EN
                    if (!zero) begin
                        mag <= mag << lzc_c;
                        exp <= exp - EXP_W'(lzc_c);
                    end
                    state <= ROUND;
`else
                    if (zero || mag[IN_W-1]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - EXP_W'(1);
                    end
`endif
                end
                ROUND: begin
                    if (zero) begin
                        float_out <= '0;
                        inexact   <= 1'b0;
                    end else begin
                        float_out <= {sign, exp_rnd_c, sum_c[FRAC_W-1:0]};
                        inexact   <= guard_c | sticky_c;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_to_float.sv
// Bench for pcm_to_float: directed conversions, rounding ties, backpressure,
// asynchronous reset mid-conversion, and a few modelled random samples.
// Honours PCM2F_FAST_NORM_EN for the expected latency.
module tb_pcm_to_float;

    logic        clk;
    logic        rst;
    logic [23:0] pcm_in;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] float_out;
    logic        inexact;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [23:0] f;
        logic        i;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] last_f;

    pcm_to_float dut (
        .clk       (clk),
        .rst       (rst),
        .pcm_in    (pcm_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .float_out (float_out),
        .inexact   (inexact),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Position of the leading one of the sample magnitude.
    function automatic int lead_pos(input logic [23:0] pcm);
        logic [23:0] m;
        int p;
        m = pcm[23] ? 24'(~pcm + 24'd1) : pcm;
        p = 0;
        for (int k = 0; k < 24; k++) if (m[k]) p = k;
        return p;
    endfunction

    function automatic int exp_lat(input logic [23:0] pcm);
`ifdef PCM2F_FAST_NORM_EN
        return 2;
`else
        if (pcm == 24'd0) return 2;
        return 25 - lead_pos(pcm);
`endif
    endfunction

    // Reference: {inexact, float}; rounding via add-(half-1+lsb)-then-truncate.
    function automatic logic [24:0] model(input logic [23:0] pcm);
        logic [23:0] m, n;
        logic [24:0] t;
        logic [17:0] r;
        int          p, e;
        logic [15:0] fr;
        if (pcm == 24'd0) return 25'd0;
        m = pcm[23] ? 24'(~pcm + 24'd1) : pcm;
        p = lead_pos(pcm);
        n = m << (23 - p);
        t = {1'b0, n} + 25'd63 + 25'(n[7]);
        r = t[24:7];
        e = 63 + p;
        if (r[17]) begin
            e++;
            fr = 16'd0;
        end else begin
            fr = r[15:0];
        end
        return {(|n[6:0]), pcm[23], 7'(e), fr};
    endfunction

    // Present one sample at posedge+1 and push its expected result.
    task automatic send(input logic [23:0] pcm, input logic [23:0] f, input logic i);
        exp_t e;
        e.f = f;
        e.i = i;
        e.lat = exp_lat(pcm);
        sb.push_back(e);
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        pcm_in   = pcm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, then pop and compare.
    task automatic collect(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            last_f = e.f;
            chk({tag, "_float"}, 32'(float_out), 32'(e.f));
            chk({tag, "_inexact"}, 32'(inexact), 32'(e.i));
            chk({tag, "_latency"}, 32'(n), 32'(e.lat));
        end
    endtask

    // Complete the output transfer and check the return to idle.
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [24:0] mr;
        logic [23:0] rp;
        rst       = 1'b1;
        pcm_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        last_f    = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_float", 32'(float_out), 32'd0);
        chk("rst_inexact", 32'(inexact), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(24'h0000C8, 24'h469000, 1'b0); collect("p200"); release_out("p200");
        send(24'hFFFFFF, 24'hBF0000, 1'b0); collect("m1");   release_out("m1");
        send(24'h000000, 24'h000000, 1'b0); collect("zero"); release_out("zero");
        send(24'h800000, 24'hD60000, 1'b0); collect("min");  release_out("min");
        send(24'h7FFFFF, 24'h560000, 1'b1); collect("max");  release_out("max");
        send(24'h020001, 24'h500000, 1'b1); collect("tie_even"); release_out("tie_even");
        send(24'h020003, 24'h500002, 1'b1); collect("tie_odd");  release_out("tie_odd");

        // out_ready already high when out_valid rises: transfer on the next edge.
        out_ready = 1'b1;
        send(24'h000001, 24'h3F0000, 1'b0); collect("ready_early"); release_out("ready_early");

        // Backpressure: result held, in_ready low, stray in_valid ignored.
        send(24'h000100, 24'h470000, 1'b0);
        collect("bp");
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_float", 32'(float_out), 32'(last_f));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            if (k == 3) begin
                pcm_in   = 24'h123456;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        release_out("bp");
        @(posedge clk);
        #1;
        chk("bp_no_stray", 32'(out_valid), 32'd0);

        // Asynchronous reset five cycles into a conversion.
        pcm_in   = 24'h000001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_float", 32'(float_out), 32'd0);
        chk("arst_inexact", 32'(inexact), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(24'h000003, 24'h408000, 1'b0); collect("after_rst"); release_out("after_rst");

        // Random samples against the model.
        for (int k = 0; k < 8; k++) begin
            rp = 24'($urandom) >> $urandom_range(0, 22);
            if ($urandom_range(0, 1) == 1) rp = 24'(~rp + 24'd1);
            mr = model(rp);
            send(rp, mr[23:0], mr[24]);
            collect("rand");
            release_out("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
